// File: rtl/cmflg_arbiter.sv
// ============================================================================
// cmflg_arbiter: two-requester round-robin arbiter sharing one multifunction gate
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmflg_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic [2:0]       s0,
  input  logic [2:0]       s1,
  output logic [1:0]       gnt,
  output logic [1:0]       vld,
  output logic             y,
  output logic             busy,
  output logic [CNT_W-1:0] ops
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic [2:0] OP_BUF  = 3'b000;
  localparam logic [2:0] OP_INV  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  logic [1:0]       r_state;
  logic             r_ptr;
  logic             r_win;
  logic             r_a;
  logic             r_b;
  logic [2:0]       r_sel;
  logic [1:0]       r_gnt;
  logic [1:0]       r_vld;
  logic             r_y;
  logic [CNT_W-1:0] r_ops;

  logic             w_win;
  logic             w_gate;

  // r_ptr names the requester that wins a tie; it always points at the non-winner.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = r_ptr;
      default: w_win = 1'b0;
    endcase
  end

  // Unknown select bits fall through to default so the result reads as x.
  always_comb begin
    w_gate = 1'b0;
    case (r_sel)
      OP_BUF:  w_gate = r_a;
      OP_INV:  w_gate = ~r_a;
      OP_AND:  w_gate = r_a & r_b;
      OP_NAND: w_gate = ~(r_a & r_b);
      OP_OR:   w_gate = r_a | r_b;
      OP_NOR:  w_gate = ~(r_a | r_b);
      OP_XOR:  w_gate = r_a ^ r_b;
      OP_XNOR: w_gate = ~(r_a ^ r_b);
      default: w_gate = 1'bx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_sel   <= OP_BUF;
      r_gnt   <= 2'b00;
      r_vld   <= 2'b00;
      r_y     <= 1'b0;
      r_ops   <= '0;
    end else begin
      r_gnt <= 2'b00;
      r_vld <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_EXEC;
            r_win   <= w_win;
            r_a     <= a[w_win];
            r_b     <= b[w_win];
            r_sel   <= w_win ? s1 : s0;
            r_gnt   <= {w_win, ~w_win};
            r_ptr   <= ~w_win;
          end
        end
        ST_EXEC: begin
          r_state <= ST_RESP;
          r_y     <= w_gate;
          r_vld   <= {r_win, ~r_win};
          r_ops   <= r_ops + CNT_W'(1);
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign vld  = r_vld;
  assign y    = r_y;
  assign busy = (r_state != ST_IDLE);
  assign ops  = r_ops;

endmodule

`default_nettype wire

// File: tb/tb_cmflg_arbiter.sv
// ============================================================================
// tb_cmflg_arbiter: scoreboard bench for cmflg_arbiter (default and 2-bit counter)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cmflg_arbiter;

  typedef struct packed {
    logic [1:0] vld;
    logic       y;
    logic [7:0] ops;
  } vexp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] a;
  logic [1:0] b;
  logic [2:0] s0;
  logic [2:0] s1;
  logic [1:0] gnt;
  logic [1:0] vld;
  logic       y;
  logic       busy;
  logic [7:0] ops;
  logic [1:0] gnt2;
  logic [1:0] vld2;
  logic       y2;
  logic       busy2;
  logic [1:0] ops2;

  int         checks;
  int         errors;
  logic [7:0] exp_ops;
  logic [1:0] prev_gnt;
  logic [3:0] tt [8];
  logic [1:0] gq [$];
  vexp_t      vq [$];

  cmflg_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .s0(s0), .s1(s1),
    .gnt(gnt), .vld(vld), .y(y), .busy(busy), .ops(ops)
  );

  cmflg_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .s0(s0), .s1(s1),
    .gnt(gnt2), .vld(vld2), .y(y2), .busy(busy2), .ops(ops2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 2'b00 && vld != 2'b00) chk("gnt_vld_overlap", {gnt, vld}, {gnt, 2'b00});
      if (gnt != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
        else chk("gnt", {30'd0, gnt}, {30'd0, gq.pop_front()});
      end
      if (vld != 2'b00) begin
        if (vq.size() == 0) chk("vld_unexpected", {30'd0, vld}, 32'd0);
        else begin
          vexp_t e;
          e = vq.pop_front();
          chk("vld", {30'd0, vld}, {30'd0, e.vld});
          chk("vld_after_gnt", {30'd0, vld}, {30'd0, prev_gnt});
          chk("y", {31'd0, y}, {31'd0, e.y});
          chk("ops", {24'd0, ops}, {24'd0, e.ops});
          chk("ops_w2", {30'd0, ops2}, {30'd0, e.ops[1:0]});
        end
      end
      prev_gnt = gnt;
    end else begin
      prev_gnt = 2'b00;
    end
  end

  // Called one step after a rising edge with the FSM in IDLE.
  task automatic op(input int idx, input logic [2:0] sel, input logic av, input logic bv,
                    input logic ey, input logic flip);
    req[idx] = 1'b1;
    a[idx]   = av;
    b[idx]   = bv;
    if (idx == 0) s0 = sel;
    else          s1 = sel;
    gq.push_back(idx == 0 ? 2'b01 : 2'b10);
    exp_ops = exp_ops + 8'd1;
    vq.push_back('{vld: (idx == 0 ? 2'b01 : 2'b10), y: ey, ops: exp_ops});
    @(posedge clk); #1;
    req = 2'b00;
    if (flip) a[idx] = ~a[idx];
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_ops = 8'd0;
    #2;
    chk("rst_gnt",  {30'd0, gnt},  32'd0);
    chk("rst_vld",  {30'd0, vld},  32'd0);
    chk("rst_y",    {31'd0, y},    32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops",  {24'd0, ops},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_ops  = 8'd0;
    prev_gnt = 2'b00;
    // Truth tables, bit index {a,b}.
    tt[0] = 4'b1100; tt[1] = 4'b0011; tt[2] = 4'b1000; tt[3] = 4'b0111;
    tt[4] = 4'b1110; tt[5] = 4'b0001; tt[6] = 4'b0110; tt[7] = 4'b1001;
    rst_n = 1'b0; req = 2'b00; a = 2'b00; b = 2'b00; s0 = 3'b000; s1 = 3'b000;
    #3;
    do_reset();

    // Single request, XOR(1,0)=1; busy must be low once the op completes.
    op(0, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    // Operand stability: NAND(1,1)=0 even though a flips during the grant.
    op(1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1);
    // Three more ops so the 2-bit counter shows 1,2,3,0,1.
    op(0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    op(1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
    op(0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);

    // Exhaustive functions from a fresh reset.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [3:0] row;
        logic [1:0] abv;
        row = tt[c];
        abv = ab[1:0];
        op(0, c[2:0], abv[1], abv[0], row[abv], 1'b0);
      end
    end
    chk("ops_32", {24'd0, ops}, 32'd32);

    // Reset during EXEC drops the operation.
    do_reset();
    req = 2'b01; a = 2'b01; s0 = 3'b000;
    gq.push_back(2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld",  {30'd0, vld}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_vld_after", {30'd0, vld}, 32'd0);
    chk("midrst_ops",       {24'd0, ops}, 32'd0);
    op(1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);

    // Contention held from reset: grants alternate 01,10,01,10.
    rst_n = 1'b0;
    exp_ops = 8'd0;
    req = 2'b11; a = 2'b01; b = 2'b10; s0 = 3'b100; s1 = 3'b010;
    for (int k = 0; k < 4; k++) begin
      gq.push_back(k[0] ? 2'b10 : 2'b01);
      exp_ops = exp_ops + 8'd1;
      vq.push_back('{vld: (k[0] ? 2'b10 : 2'b01), y: ~k[0], ops: exp_ops});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    req = 2'b00;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    chk("gq_drained", gq.size(), 32'd0);
    chk("vq_drained", vq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmflg_arbiter.md
CMFLG_ARBITER -- requirements
Module: cmflg_arbiter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  2  per-requester request, level; bit i = requester i.
REQ-006 a  input  2  per-requester logic input a; bit i belongs to requester i.
REQ-007 b  input  2  per-requester logic input b; bit i belongs to requester i.
REQ-008 s0  input  3  requester 0 gate select; codes BUF=000, INV=001, AND=010, NAND=011, OR=100, NOR=101, XOR=110, XNOR=111.
REQ-009 s1  input  3  requester 1 gate select; same codes as s0.
REQ-010 gnt  output  2  one-hot, one-cycle grant pulse; operands captured.
REQ-011 vld  output  2  one-hot, one-cycle result-valid pulse.
REQ-012 y  output  1  registered gate result; meaningful only while vld != 0.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 ops  output  CNT_W  count of completed operations, wraps modulo 2^CNT_W.

Function
REQ-015 The block SHALL time-share one multifunction logic gate (functions per REQ-008) between two requesters.
REQ-016 The FSM SHALL have three states, IDLE, EXEC and RESP, with IDLE->EXEC on any req bit set at a rising edge, EXEC->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-017 req SHALL be sampled only in IDLE; req is ignored in EXEC and RESP.
REQ-018 On IDLE->EXEC the block SHALL latch the winner index and the winner's a bit, b bit and select code, and SHALL set gnt[winner]=1 for exactly the EXEC cycle.
REQ-019 In EXEC the gate SHALL evaluate only the latched operands, so operand changes after the grant edge have no effect.
REQ-020 On EXEC->RESP the block SHALL register y = f(s, a, b), set vld[winner]=1 for exactly the RESP cycle, and increment ops by 1.
REQ-021 Latency SHALL be fixed: req seen at edge E0 -> gnt after E0 -> vld and y after E1 -> IDLE after E2; maximum throughput is one operation per 3 cycles.
REQ-022 Arbitration SHALL be round-robin: when only one req bit is set, that requester wins; when both are set, the requester not served last wins.
REQ-023 The priority pointer SHALL update on IDLE->EXEC to point at the non-winner.
REQ-024 A requester SHALL deassert req at the edge where it samples gnt high; a req still high in IDLE at E2 is a new request.
REQ-025 BUF and INV SHALL use only a; b is don't-care for those codes.
REQ-026 A latched select code containing X or Z SHALL produce y = x, with the FSM and the vld pulse unaffected.
REQ-027 The ops counter SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-028 gnt and vld SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE, gnt=0, vld=0, y=0, busy=0, ops=0, and the priority pointer SHALL favour requester 0, all asynchronously.
REQ-030 Reset asserted in EXEC or RESP SHALL drop the in-flight operation: no vld pulse and no ops increment for it.
REQ-031 After rst_n rises, the first rising edge SHALL be treated as an IDLE sample.

Verification
REQ-032 Single request: req=01, a[0]=1, b[0]=0, s0=XOR -> gnt=01 for 1 cycle, next cycle vld=01 and y=1, ops=1, busy low after 3 cycles.
REQ-033 Contention: req=11 held continuously from reset -> grants alternate 01,10,01,10 every 3 cycles; vld follows each grant by 1 cycle.
REQ-034 Operand stability: requester 1 with s1=NAND, a[1]=b[1]=1 changes a[1] to 0 in the gnt cycle -> y=0 (latched operands used).
REQ-035 Exhaustive functions: all 8 select codes x 4 (a,b) combinations on requester 0 -> y matches the truth table every time; ops=32.
REQ-036 Reset mid-operation: rst_n pulsed low during EXEC -> no vld, ops unchanged at 0, next req=10 granted to requester 1 normally.
REQ-037 Wrap: CNT_W=2, 5 operations -> ops sequence 1,2,3,0,1.
